serial_add_deser: RTL and testbench

//  Bit-serial full-adder receiver and deserializer.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_fa_cell.sv | 13 +
 rtl/serial_add_deser.sv | 104 ++++++++++
 tb/tb_serial_add_deser.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/deserializer.
package serial_add_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // Counter width for an arbitrary word length; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder matching the standard-cell carry structure.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_deser.sv
// Bit-serial add/subtract receiver: LSB-first bit pairs in, parallel word plus flags out.
module serial_add_deser
    import serial_add_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int                 CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sub;
    logic             cmsb;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic first, last, fire;
    logic sub_now, bb, ci, s, co;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign fire      = in_valid & in_ready;
    assign first     = (cnt == '0);
    assign last      = (cnt == CNT_LAST);

    // Bit 0 takes the subtract mode and the +1 carry-in straight from the port.
    assign sub_now = first ? in_sub : sub;
    assign bb      = in_b ^ sub_now;
    assign ci      = first ? in_sub : carry;

    serial_fa_cell u_fa (
        .a  (in_a),
        .b  (bb),
        .ci (ci),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ACCUM;
            cnt    <= '0;
            carry  <= 1'b0;
            sub    <= 1'b0;
            cmsb   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (clr) begin
            state <= ACCUM;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (fire) begin
                        sum_q <= {s, sum_q[WIDTH-1:1]};
                        carry <= co;
                        if (first) sub <= in_sub;
                        if (last) begin
                            cmsb   <= ci;
                            cout_q <= co;
                            ovf_q  <= SIGNED ? (ci ^ co) : (sub_now ? ~co : co);
                            state  <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        cnt   <= '0;
                        carry <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_deser.sv
// Directed bench: one unsigned and one signed instance driven by the same serial stream.
module tb_serial_add_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_a = 1'b0;
    logic         in_b = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_ready = 1'b0;
    logic         rdy_u, rdy_s, vld_u, vld_s;
    logic [W-1:0] sum_u, sum_s;
    logic         cout_u, cout_s, ovf_u, ovf_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_deser #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy_u), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(vld_u), .out_ready(out_ready),
        .out_sum(sum_u), .out_cout(cout_u), .out_ovf(ovf_u)
    );

    serial_add_deser #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy_s), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(vld_s), .out_ready(out_ready),
        .out_sum(sum_s), .out_cout(cout_s), .out_ovf(ovf_s)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf_u;
        logic         ovf_s;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one word; gaps inserts random idle cycles, in_sub on beats 1..7 is always perturbed.
    task automatic send_beats(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                              input int nbeats, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_a     = 1'($urandom);
                    in_b     = 1'($urandom);
                    in_sub   = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_a     = a[i];
            in_b     = b[i];
            in_sub   = (i == 0) ? sub : (gaps ? 1'($urandom) : ~sub);
            if (i == nbeats - 1 && nbeats == W) begin
                chk("valid_low_before_last", {30'd0, vld_u, vld_s}, 32'd0);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_valid"},  {30'd0, vld_u, vld_s}, 32'd3);
        chk({tag, "_ready"},  {30'd0, rdy_u, rdy_s}, 32'd0);
        chk({tag, "_sum_u"},  32'(sum_u), 32'(v.sum));
        chk({tag, "_sum_s"},  32'(sum_s), 32'(v.sum));
        chk({tag, "_cout"},   {30'd0, cout_u, cout_s}, {30'd0, v.cout, v.cout});
        chk({tag, "_ovf_u"},  32'(ovf_u), 32'(v.ovf_u));
        chk({tag, "_ovf_s"},  32'(ovf_s), 32'(v.ovf_s));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("after_consume_ready", {30'd0, rdy_u, rdy_s}, 32'd3);
        chk("after_consume_valid", {30'd0, vld_u, vld_s}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, {30'd0, vld_u, vld_s}, 32'd0);
        chk({tag, "_ready"}, {30'd0, rdy_u, rdy_s}, 32'd3);
        chk({tag, "_sum"},   {16'd0, sum_u, sum_s}, 32'd0);
        chk({tag, "_flags"}, {28'd0, cout_u, cout_s, ovf_u, ovf_s}, 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [W-1:0] hold_sum;
        logic         hold_c, hold_o;

        //        a      b      sub   sum    cout  ovf_u ovf_s
        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};

        #12;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            send_beats(vecs[i].a, vecs[i].b, vecs[i].sub, W, 1'b0);
            check_result($sformatf("vec%0d", i), vecs[i]);
            consume();
        end

        // Backpressure: result must sit still while out_ready is low.
        v = vecs[0];
        send_beats(v.a, v.b, v.sub, W, 1'b0);
        hold_sum = sum_u; hold_c = cout_s; hold_o = ovf_s;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a     = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_ready", {30'd0, rdy_u, rdy_s}, 32'd0);
            chk("bp_stable", {sum_u, 6'd0, cout_s, ovf_s}, {v.sum, 6'd0, v.cout, v.ovf_s});
        end
        in_valid = 1'b0;
        chk("bp_hold_snapshot", {hold_sum, hold_c, hold_o}, {v.sum, v.cout, v.ovf_s});
        consume();
        send_beats(vecs[1].a, vecs[1].b, vecs[1].sub, W, 1'b0);
        check_result("bp_next", vecs[1]);
        consume();

        // Async reset after 3 beats of a word that would leave residue.
        send_beats(8'hFF, 8'hFF, 1'b1, 3, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_beats(vecs[3].a, vecs[3].b, vecs[3].sub, W, 1'b0);
        check_result("after_rst", vecs[3]);
        consume();

        // clr asserted alongside beat 5 with in_valid high: the beat is dropped.
        send_beats(8'hFF, 8'hFF, 1'b0, 5, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_accum_valid", {30'd0, vld_u, vld_s}, 32'd0);
        send_beats(vecs[3].a, vecs[3].b, vecs[3].sub, W, 1'b0);
        check_result("after_clr", vecs[3]);

        // clr in HOLD drops the result.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_hold_valid", {30'd0, vld_u, vld_s}, 32'd0);
        chk("clr_hold_ready", {30'd0, rdy_u, rdy_s}, 32'd3);

        // Stalled delivery with noisy in_sub on later beats.
        for (int i = 0; i < 3; i++) begin
            send_beats(vecs[i].a, vecs[i].b, vecs[i].sub, W, 1'b1);
            check_result($sformatf("stall%0d", i), vecs[i]);
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
